// File: rtl/jkff_to_srff_reg.sv
// W-bit SR register built from per-bit JK storage, with illegal-input (s=r=1)
// detection, sticky error status, a saturating error counter and an OK/FAULT/LOCK FSM.
module jkff_to_srff_reg #(
  parameter int W      = 4,
  parameter int LOCK_N = 3,
  localparam int IW    = (W > 1) ? $clog2(W) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [W-1:0]  s,
  input  logic [W-1:0]  r,
  input  logic          clr_err,
  output logic [W-1:0]  q,
  output logic [W-1:0]  qb,
  output logic          illegal,
  output logic          err_sticky,
  output logic [7:0]    err_cnt,
  output logic [IW-1:0] err_idx,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_FAULT = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  state_t        state_reg;
  logic [W-1:0]  q_reg;
  logic [W-1:0]  q_next;
  logic          illegal_reg;
  logic          sticky_reg;
  logic [7:0]    cnt_reg;
  logic [IW-1:0] idx_reg;
  logic [3:0]    run_reg;
  logic [3:0]    run_inc;
  logic [IW-1:0] low_idx;
  logic          active;
  logic          illegal_ev;

  assign active     = en && (state_reg != ST_LOCK);
  assign illegal_ev = active && ((s & r) != '0);
  assign run_inc    = (run_reg == 4'hF) ? run_reg : run_reg + 4'd1;

  // JK next-state per bit; J and K are never both 1, so the toggle case is unreachable.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      logic j_bit;
      logic k_bit;
      assign j_bit      = s[gi] & ~r[gi];
      assign k_bit      = r[gi] & ~s[gi];
      assign q_next[gi] = (j_bit & ~q_reg[gi]) | (~k_bit & q_reg[gi]);
    end
  endgenerate

  always_comb begin
    low_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (s[i] && r[i]) low_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg       <= '0;
      illegal_reg <= 1'b0;
      sticky_reg  <= 1'b0;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      run_reg     <= '0;
      state_reg   <= ST_OK;
    end else begin
      if (active) q_reg <= q_next;
      illegal_reg <= illegal_ev && !clr_err;
      if (clr_err) begin
        sticky_reg <= 1'b0;
        cnt_reg    <= '0;
        idx_reg    <= '0;
        run_reg    <= '0;
        state_reg  <= ST_OK;
      end else if (illegal_ev) begin
        sticky_reg <= 1'b1;
        if (cnt_reg != 8'hFF) cnt_reg <= cnt_reg + 8'd1;
        if (!sticky_reg) idx_reg <= low_idx;
        run_reg <= run_inc;
        // Both OK and FAULT escalate once the consecutive run hits LOCK_N.
        if (run_inc >= 4'(LOCK_N)) state_reg <= ST_LOCK;
        else                       state_reg <= ST_FAULT;
      end else if (en) begin
        run_reg <= '0;
      end
    end
  end

  assign q          = q_reg;
  assign qb         = ~q_reg;
  assign illegal    = illegal_reg;
  assign err_sticky = sticky_reg;
  assign err_cnt    = cnt_reg;
  assign err_idx    = idx_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_jkff_to_srff_reg.sv
// Directed bench for jkff_to_srff_reg (W=4, LOCK_N=3) with hand-computed expectations.
module tb_jkff_to_srff_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] s;
  logic [3:0] r;
  logic       clr_err;
  logic [3:0] q;
  logic [3:0] qb;
  logic       illegal;
  logic       err_sticky;
  logic [7:0] err_cnt;
  logic [1:0] err_idx;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  jkff_to_srff_reg #(.W(4), .LOCK_N(3)) dut (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(q), .qb(qb), .illegal(illegal), .err_sticky(err_sticky),
    .err_cnt(err_cnt), .err_idx(err_idx), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; s = '0; r = '0; clr_err = 1'b0;
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; s = '0; r = '0; clr_err = 1'b0;
    #2;
    n_cmp++; if (q !== 4'b0000) begin n_err++; $display("FAIL reset_q got %b exp 0000", q); end
    n_cmp++; if (qb !== 4'b1111) begin n_err++; $display("FAIL reset_qb got %b exp 1111", qb); end
    n_cmp++; if ({illegal, err_sticky} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b exp 00", {illegal, err_sticky}); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", err_cnt); end
    n_cmp++; if (err_idx !== 2'd0) begin n_err++; $display("FAIL reset_idx got %0d exp 0", err_idx); end
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state); end
    $display("test_reset done");
    rst = 1'b1;
    tick();
  endtask

  task automatic test_set_reset();
    en = 1'b1; s = 4'b0101; r = 4'b0000;
    #1;
    n_cmp++; if (q !== 4'b0000) begin n_err++; $display("FAIL latency_q got %b exp 0000", q); end
    tick();
    n_cmp++; if (q !== 4'b0101) begin n_err++; $display("FAIL set_q got %b exp 0101", q); end
    n_cmp++; if (qb !== 4'b1010) begin n_err++; $display("FAIL set_qb got %b exp 1010", qb); end
    n_cmp++; if (state !== 2'd0 || illegal !== 1'b0) begin n_err++; $display("FAIL set_status got st=%0d ill=%b exp st=0 ill=0", state, illegal); end
    s = 4'b1000; r = 4'b0001;
    tick();
    n_cmp++; if (q !== 4'b1100) begin n_err++; $display("FAIL sr_q got %b exp 1100", q); end
    s = '0; r = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (q !== 4'b1100) begin n_err++; $display("FAIL hold_q[%0d] got %b exp 1100", i, q); end
    end
    en = 1'b0; s = 4'b1111; r = 4'b1111;
    tick();
    n_cmp++; if (q !== 4'b1100) begin n_err++; $display("FAIL en0_q got %b exp 1100", q); end
    n_cmp++; if ({illegal, err_sticky, state} !== 4'b0000) begin n_err++; $display("FAIL en0_status got %b exp 0000", {illegal, err_sticky, state}); end
    en = 1'b1; s = 4'b0000; r = 4'b1111;
    tick();
    n_cmp++; if (q !== 4'b0000) begin n_err++; $display("FAIL clear_q got %b exp 0000", q); end
    $display("test_set_reset done");
  endtask

  task automatic test_illegal();
    do_reset();
    en = 1'b1; s = 4'b0110; r = 4'b0010;
    tick();
    n_cmp++; if (q !== 4'b0100) begin n_err++; $display("FAIL ill_q got %b exp 0100", q); end
    n_cmp++; if (illegal !== 1'b1) begin n_err++; $display("FAIL ill_flag got %b exp 1", illegal); end
    n_cmp++; if (err_cnt !== 8'd1) begin n_err++; $display("FAIL ill_cnt got %0d exp 1", err_cnt); end
    n_cmp++; if (err_idx !== 2'd1) begin n_err++; $display("FAIL ill_idx got %0d exp 1", err_idx); end
    n_cmp++; if (state !== 2'd1 || err_sticky !== 1'b1) begin n_err++; $display("FAIL ill_state got st=%0d sticky=%b exp st=1 sticky=1", state, err_sticky); end
    s = '0; r = '0;
    tick();
    n_cmp++; if (illegal !== 1'b0 || state !== 2'd1) begin n_err++; $display("FAIL ill_after got ill=%b st=%0d exp ill=0 st=1", illegal, state); end
    s = 4'b0001; r = 4'b0001;
    tick();
    n_cmp++; if (err_idx !== 2'd1 || err_cnt !== 8'd2) begin n_err++; $display("FAIL ill2 got idx=%0d cnt=%0d exp idx=1 cnt=2", err_idx, err_cnt); end
    n_cmp++; if (q !== 4'b0100 || state !== 2'd1) begin n_err++; $display("FAIL ill2_q got q=%b st=%0d exp q=0100 st=1", q, state); end
    s = '0; r = '0; clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_cmp++; if ({state, err_cnt, err_sticky} !== 11'd0) begin n_err++; $display("FAIL ill_clr got st=%0d cnt=%0d sticky=%b exp all 0", state, err_cnt, err_sticky); end
    $display("test_illegal done");
  endtask

  task automatic test_lock();
    en = 1'b1; s = 4'b0011; r = 4'b0011;
    tick();
    tick();
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL lock_pre got st=%0d exp 1", state); end
    tick();
    n_cmp++; if (state !== 2'd2 || err_cnt !== 8'd3) begin n_err++; $display("FAIL lock_enter got st=%0d cnt=%0d exp st=2 cnt=3", state, err_cnt); end
    n_cmp++; if (err_idx !== 2'd0) begin n_err++; $display("FAIL lock_idx got %0d exp 0", err_idx); end
    s = 4'b1111; r = 4'b0000;
    tick();
    n_cmp++; if (q !== 4'b0100 || state !== 2'd2) begin n_err++; $display("FAIL lock_freeze got q=%b st=%0d exp q=0100 st=2", q, state); end
    s = 4'b1111; r = 4'b1111;
    tick();
    n_cmp++; if (err_cnt !== 8'd3 || illegal !== 1'b0) begin n_err++; $display("FAIL lock_noerr got cnt=%0d ill=%b exp cnt=3 ill=0", err_cnt, illegal); end
    s = '0; r = '0; clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_cmp++; if (state !== 2'd0 || err_cnt !== 8'd0 || err_sticky !== 1'b0) begin n_err++; $display("FAIL lock_clr got st=%0d cnt=%0d sticky=%b exp 0/0/0", state, err_cnt, err_sticky); end
    $display("test_lock done");
  endtask

  task automatic test_saturate();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 255; i++) begin
      s = 4'b0001; r = 4'b0001;
      tick();
      s = 4'b0000; r = 4'b0000;
      tick();
    end
    n_cmp++; if (err_cnt !== 8'd255 || state !== 2'd1) begin n_err++; $display("FAIL sat_pre got cnt=%0d st=%0d exp cnt=255 st=1", err_cnt, state); end
    s = 4'b0100; r = 4'b0100;
    tick();
    n_cmp++; if (err_cnt !== 8'd255 || state !== 2'd1) begin n_err++; $display("FAIL sat_hold got cnt=%0d st=%0d exp cnt=255 st=1", err_cnt, state); end
    n_cmp++; if (err_idx !== 2'd0) begin n_err++; $display("FAIL sat_idx got %0d exp 0", err_idx); end
    $display("test_saturate done");
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; s = 4'b1010; r = 4'b0000;
    tick();
    s = 4'b0001; r = 4'b0001;
    tick(); tick(); tick();
    n_cmp++; if (q !== 4'b1010 || state !== 2'd2) begin n_err++; $display("FAIL arst_pre got q=%b st=%0d exp q=1010 st=2", q, state); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (q !== 4'b0000 || qb !== 4'b1111) begin n_err++; $display("FAIL arst_q got q=%b qb=%b exp 0000/1111", q, qb); end
    n_cmp++; if (state !== 2'd0 || err_cnt !== 8'd0) begin n_err++; $display("FAIL arst_state got st=%0d cnt=%0d exp 0/0", state, err_cnt); end
    s = 4'b0001; r = 4'b0000;
    #1;
    rst = 1'b1;
    tick();
    n_cmp++; if (q !== 4'b0001 || state !== 2'd0) begin n_err++; $display("FAIL arst_resume got q=%b st=%0d exp q=0001 st=0", q, state); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_set_reset();
    test_illegal();
    test_lock();
    test_saturate();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jkff_to_srff_reg.md
JKFF_TO_SRFF_REG -- requirements
Module: jkff_to_srff_reg

Interface
REQ-001 Parameter W, default 4: number of SR register bits.
REQ-002 Parameter LOCK_N, default 3, range 1..15: consecutive illegal cycles that force LOCK.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  update enable; when 0, all state holds.
REQ-006 s  input  W  per-bit set request.
REQ-007 r  input  W  per-bit reset request.
REQ-008 clr_err  input  1  synchronous clear of error status and the lock.
REQ-009 q  output  W  registered SR state.
REQ-010 qb  output  W  always the bitwise complement of q.
REQ-011 illegal  output  1  registered; 1 for one cycle after any enabled cycle with some bit having s=r=1.
REQ-012 err_sticky  output  1  set by any illegal cycle; held until clr_err or reset.
REQ-013 err_cnt  output  8  count of illegal cycles, saturating at 255.
REQ-014 err_idx  output  clog2(W), minimum 1  lowest bit index of the first illegal event since the last clear.
REQ-015 state  output  2  FSM state: OK=0, FAULT=1, LOCK=2.

Function
REQ-016 Each bit of q is held in a JK flip-flop with J=s&~r and K=r&~s, so the register gives SR behaviour built from JK storage.
REQ-017 Bit behaviour on an enabled cycle (en=1, state≠LOCK): s,r=10 -> q=1; 01 -> q=0; 00 -> hold; 11 -> hold, never toggle.
REQ-018 Latency: q and qb change on the first rising edge after the input is applied; there is no combinational path from s, r or en to any output.
REQ-019 An illegal cycle is any cycle with en=1, state≠LOCK and (s&r)≠0.
REQ-020 On an illegal cycle, the legal bits still update per REQ-017.
REQ-021 On an illegal cycle, err_cnt increments unless it is already 255, err_sticky is set, and illegal=1 on the next cycle.
REQ-022 On the first illegal cycle since a clear, err_idx captures the lowest set index of s&r; later illegal cycles leave err_idx unchanged.
REQ-023 An internal run counter counts consecutive illegal cycles; any enabled legal cycle resets it to 0, and cycles with en=0 leave it unchanged.
REQ-024 FSM transition OK->FAULT on the first illegal cycle.
REQ-025 FSM transition FAULT->LOCK when the run counter reaches LOCK_N; with LOCK_N=1, the first illegal cycle goes OK->LOCK directly.
REQ-026 FSM transition FAULT->OK only on clr_err.
REQ-027 FSM transition LOCK->OK only on clr_err.
REQ-028 In LOCK, q, err_cnt and err_idx freeze regardless of en, s and r, and illegal=0.
REQ-029 clr_err=1 on an edge clears err_sticky, err_cnt, err_idx and the run counter, sets state to OK, and takes priority over an illegal event in the same cycle; q still updates per REQ-017 in that cycle.
REQ-030 With en=0, q, the FSM and all error status hold, and illegal=0 next cycle; clr_err still acts.

Reset
REQ-031 When rst=0, immediately and independent of clk: q=0, qb=all ones, illegal=0, err_sticky=0, err_cnt=0, err_idx=0, run counter=0, state=OK.
REQ-032 Reset asserted mid-operation, including in LOCK, overrides everything; normal operation resumes on the first rising edge after rst returns to 1.

Verification
REQ-033 Reset then en=1, s=4'b0101, r=4'b0000 for one edge -> q=4'b0101, qb=4'b1010, state=OK, illegal=0.
REQ-034 From q=4'b0101, apply s=4'b1000, r=4'b0001 -> q=4'b1100; then s=r=0 for 3 edges -> q stays 4'b1100.
REQ-035 From q=4'b0000, apply s=4'b0110, r=4'b0010 -> q=4'b0100, illegal=1 next cycle, err_cnt=1, err_idx=1, state=FAULT.
REQ-036 With LOCK_N=3, apply 3 consecutive illegal cycles -> state=LOCK, err_cnt=3; then s=4'b1111, r=0 -> q unchanged; then clr_err -> state=OK, err_cnt=0, err_sticky=0.
REQ-037 Force err_cnt to 255 via repeated illegal/legal alternation, then one more illegal cycle -> err_cnt stays 255 and state=FAULT.
REQ-038 Assert rst=0 between clock edges while in LOCK with q=4'b1010 -> q=0 and state=OK without waiting for a clock edge.
